riscv_mem_responder: RTL and testbench

Memory-side responder for the multi-cycle RISC-V core's unified instruction/data bus. It accepts one read or write request at a time from the core's address/write-data outputs. It services each request from an internal word array after a fixed, parameterised number of wait states, then returns a one-cycle response pulse with read data and an error flag. It sits between the core top level and the memory-mapped address space, and replaces a zero-latency combinational memory so the controller's wait handling can be exercised.

---
 rtl/riscv_mem_responder_if.sv | 23 ++
 rtl/riscv_mem_responder.sv | 136 +++++++++++++
 tb/tb_riscv_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_responder_if.sv
// Request/response bus between the core and the wait-state memory responder.
// The core drives the request fields; the responder drives the handshake and response.
interface riscv_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/riscv_mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits WAIT_CYCLES,
// then returns a one-cycle response from a byte-lane word array.
module riscv_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_mem_responder_if.slave  bus
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_is_read;
    logic        r_err;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_commit;
    logic        w_addr_err;
    logic        w_valid;
    logic        w_cur_we;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic [3:0]  w_cur_wstrb;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rd_word;

    // With zero wait states the commit edge is the acceptance edge, so the
    // live bus fields are used instead of the not-yet-latched copies.
    always_comb begin
        w_cur_we    = r_we;
        w_cur_addr  = r_addr;
        w_cur_wdata = r_wdata;
        w_cur_wstrb = r_wstrb;
        if (r_state == IDLE) begin
            w_cur_we    = bus.we;
            w_cur_addr  = bus.addr;
            w_cur_wdata = bus.wdata;
            w_cur_wstrb = bus.wstrb;
        end
    end

    assign w_idx      = w_cur_addr[AW+1:2];
    assign w_addr_err = (w_cur_addr[1:0] != 2'b00) ||
                        (w_cur_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_accept     = (r_state == IDLE) && bus.req;
    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
    assign w_commit     = w_enter_resp && !rst && w_cur_we && !w_addr_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_is_read <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_wstrb <= bus.wstrb;
            end
            if (w_enter_resp) begin
                r_is_read <= !w_cur_we;
                r_err     <= w_addr_err;
            end
        end
    end

    // One byte-wide RAM per lane keeps partial writes a plain write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (w_commit && w_cur_wstrb[gi]) begin
                    r_mem[w_idx] <= w_cur_wdata[8*gi +: 8];
                end
                r_q <= r_mem[w_idx];
            end

            assign w_rd_word[8*gi +: 8] = r_q;
        end
    endgenerate

    assign w_valid    = (r_state == RESP) && !rst;
    assign bus.ready  = (r_state == IDLE) && !rst;
    assign bus.rvalid = w_valid;
    assign bus.err    = w_valid && r_err;
    assign bus.rdata  = (w_valid && r_is_read && !r_err) ? w_rd_word : 32'd0;
endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboarded bench for riscv_mem_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_riscv_mem_responder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          acc;
    } req_t;

    req_t        sbq[$];
    logic [31:0] model [int];

    riscv_mem_responder_if b2();
    riscv_mem_responder_if b0();

    riscv_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    riscv_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    always #5 clk = ~clk;

    // Response monitor for the two-wait-state instance
    always @(negedge clk) begin
        req_t        e;
        logic [31:0] exp_d;
        logic [31:0] nw;
        logic        exp_e;
        int          idx;
        cyc++;
        if (rst) begin
            sbq.delete();
        end else begin
            if (b2.rvalid) begin
                resp_count++;
                last_rdata = b2.rdata;
                last_err   = b2.err;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rvalid cycle %0d rdata %h err %b", cyc, b2.rdata, b2.err);
                end else begin
                    e     = sbq.pop_front();
                    exp_e = (e.addr[1:0] != 2'b00) || (e.addr[31:2] >= 30'd1024);
                    idx   = int'(e.addr[31:2]);
                    exp_d = 32'd0;
                    if (!exp_e) begin
                        nw = model.exists(idx) ? model[idx] : 32'd0;
                        if (e.we) begin
                            for (int b = 0; b < 4; b++)
                                if (e.wstrb[b]) nw[8*b +: 8] = e.wdata[8*b +: 8];
                            model[idx] = nw;
                        end else begin
                            exp_d = nw;
                        end
                    end
                    if (b2.rdata !== exp_d) begin
                        errors++;
                        $display("FAIL rdata addr %h got %h want %h", e.addr, b2.rdata, exp_d);
                    end
                    checks++;
                    if (b2.err !== exp_e) begin
                        errors++;
                        $display("FAIL err addr %h got %b want %b", e.addr, b2.err, exp_e);
                    end
                    checks++;
                    if ((cyc - e.acc) != 3) begin
                        errors++;
                        $display("FAIL latency addr %h got %0d want 3", e.addr, cyc - e.acc);
                    end
                end
            end
            if (b2.ready && b2.req) begin
                e.we = b2.we; e.addr = b2.addr; e.wdata = b2.wdata; e.wstrb = b2.wstrb;
                e.acc = cyc;
                sbq.push_back(e);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
        int n = 0;
        @(posedge clk); #1;
        b2.req = 1'b1; b2.we = we; b2.addr = addr; b2.wdata = wdata; b2.wstrb = wstrb;
        @(negedge clk);
        while (!b2.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!b2.ready) begin
            errors++;
            $display("FAIL accept_timeout addr %h ready %b want 1", addr, b2.ready);
        end
        @(posedge clk); #1;
        b2.req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sbq.size() != 0 || !b2.ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0 || !b2.ready) begin
            errors++;
            $display("FAIL drain_timeout pending %0d want 0", sbq.size());
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
        do_req(we, addr, wdata, wstrb);
        drain();
        $display("xfer we=%b addr=%h wdata=%h wstrb=%b -> rdata=%h err=%b",
                 we, addr, wdata, wstrb, last_rdata, last_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h0; b2.wdata = 32'h0; b2.wstrb = 4'h0;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = 32'h0; b0.wdata = 32'h0; b0.wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (b2.ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b want 0", b2.ready); end
            checks++; if (b2.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", b2.rvalid); end
            checks++; if (b2.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", b2.rdata); end
            checks++; if (b2.err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b want 0", b2.err); end
        end
        @(posedge clk); #1;
        rst = 1'b0; b2.req = 1'b0;
        @(negedge clk);
        checks++; if (b2.ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", b2.ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (b2.rvalid !== 1'b0) begin errors++; $display("FAIL reset_accepted rvalid %b want 0", b2.rvalid); end
        end
        $display("reset done");
    endtask

    task automatic test_write_read();
        xfer(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 32'h40, 32'h0, 4'h0);
        checks++; if (last_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_40 got %h want deadbeef", last_rdata); end
    endtask

    task automatic test_byte_lanes();
        xfer(1'b1, 32'h40, 32'h11223344, 4'b0101);
        xfer(1'b0, 32'h40, 32'h0, 4'h0);
        checks++; if (last_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL lanes got %h want de22be44", last_rdata); end
        xfer(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000);
        xfer(1'b0, 32'h40, 32'h0, 4'h0);
        checks++; if (last_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL zero_strb got %h want de22be44", last_rdata); end
    endtask

    task automatic test_errors();
        xfer(1'b1, 32'h0, 32'hAAAA5555, 4'hF);
        xfer(1'b0, 32'h42, 32'h0, 4'h0);
        checks++; if (last_err !== 1'b1 || last_rdata !== 32'd0)
            begin errors++; $display("FAIL misalign got err %b rdata %h want 1 0", last_err, last_rdata); end
        xfer(1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF);
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL oor_write err %b want 1", last_err); end
        xfer(1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (last_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL word0 got %h want aaaa5555", last_rdata); end
        xfer(1'b1, 32'hFFC, 32'h13579BDF, 4'hF);
        xfer(1'b0, 32'hFFC, 32'h0, 4'h0);
        checks++; if (last_rdata !== 32'h13579BDF || last_err !== 1'b0)
            begin errors++; $display("FAIL top_word got %h err %b want 13579bdf 0", last_rdata, last_err); end
        xfer(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0);
    endtask

    task automatic test_wait_toggle();
        int rc0;
        rc0 = resp_count;
        do_req(1'b0, 32'h40, 32'h0, 4'h0);
        b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h44; b2.wdata = 32'hFFFFFFFF; b2.wstrb = 4'hF;
        @(posedge clk); #1; b2.req = 1'b0;
        @(posedge clk); #1; b2.req = 1'b1;
        @(posedge clk); #1; b2.req = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        checks++; if (resp_count - rc0 != 1) begin errors++; $display("FAIL toggle_responses got %0d want 1", resp_count - rc0); end
        $display("toggle responses=%0d", resp_count - rc0);
    endtask

    task automatic test_reset_mid();
        int rc0;
        xfer(1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
        rc0 = resp_count;
        do_req(1'b1, 32'h80, 32'h12345678, 4'hF);
        @(posedge clk); #1; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (b2.rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got %b want 0", b2.rvalid); end
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (resp_count != rc0) begin errors++; $display("FAIL dropped_resp got %0d want 0", resp_count - rc0); end
        xfer(1'b0, 32'h80, 32'h0, 4'h0);
        checks++; if (last_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_rst_data got %h want cafef00d", last_rdata); end
    endtask

    task automatic test_back_to_back();
        int   pulses = 0;
        logic exp_ready;
        @(posedge clk); #1;
        b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h10; b0.wdata = 32'hFFFFFFFF; b0.wstrb = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_ready = (i % 2 == 0);
            checks++; if (b0.ready !== exp_ready)   begin errors++; $display("FAIL b2b_ready i=%0d got %b want %b", i, b0.ready, exp_ready); end
            checks++; if (b0.rvalid !== !exp_ready) begin errors++; $display("FAIL b2b_rvalid i=%0d got %b want %b", i, b0.rvalid, !exp_ready); end
            checks++; if (b0.rdata !== 32'd0 || b0.err !== 1'b0)
                begin errors++; $display("FAIL b2b_resp i=%0d got %h %b want 0 0", i, b0.rdata, b0.err); end
            if (b0.rvalid) pulses++;
        end
        @(posedge clk); #1; b0.req = 1'b0;
        checks++; if (pulses != 10) begin errors++; $display("FAIL b2b_pulses got %0d want 10", pulses); end
        $display("back_to_back pulses=%0d", pulses);
        @(posedge clk); #1;
        b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h20; b0.wdata = 32'h0BADCAFE; b0.wstrb = 4'hF;
        @(negedge clk);
        checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL w0_ready got %b want 1", b0.ready); end
        @(posedge clk); #1; b0.req = 1'b0;
        @(negedge clk);
        checks++; if (b0.rvalid !== 1'b1 || b0.rdata !== 32'd0)
            begin errors++; $display("FAIL w0_write got %b %h want 1 0", b0.rvalid, b0.rdata); end
        @(posedge clk); #1;
        b0.req = 1'b1; b0.we = 1'b0;
        @(negedge clk);
        checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL w0_ready2 got %b want 1", b0.ready); end
        @(posedge clk); #1; b0.req = 1'b0;
        @(negedge clk);
        checks++; if (b0.rvalid !== 1'b1 || b0.rdata !== 32'h0BADCAFE)
            begin errors++; $display("FAIL w0_read got %b %h want 1 0badcafe", b0.rvalid, b0.rdata); end
        $display("w0 read rdata=%h", b0.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_wait_toggle();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
